mips_run_ctrl: RTL and testbench

Synthesizable run controller that sits between the top-level harness and the `mips` core. It holds the core in reset for a programmable number of cycles after a start request, then releases it. While the core runs, it counts cycles and retired instructions. It ends the run either on a self-loop halt (the same PC retired repeatedly) or on a cycle-budget timeout. It replaces the bare clock/reset stimulus with a reusable, parametrised sequencer that can be restarted without a global reset.

---
 rtl/mips_run_pkg.sv | 9 +
 rtl/mips_run_ctrl_sat_counter.sv | 17 +
 rtl/mips_run_ctrl.sv | 105 ++++++++++
 tb/tb_mips_run_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mips_run_pkg.sv
// mips_run_pkg: shared state encoding and default parameters for the run controller.
package mips_run_pkg;
    typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_DONE, S_TIMEOUT} state_e;
    localparam int DEF_PC_WIDTH    = 32;
    localparam int DEF_CNT_WIDTH   = 32;
    localparam int DEF_RST_CYCLES  = 4;
    localparam int DEF_HALT_REPEAT = 3;
    localparam int DEF_MAX_CYCLES  = 100000;
endpackage

// File: rtl/mips_run_ctrl_sat_counter.sv
// sat_counter: clearable, enabled up-counter that sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: sequences core reset/run, counts cycles and retirements,
// and ends the run on a same-PC self-loop halt or a cycle-budget timeout.
module mips_run_ctrl import mips_run_pkg::*; #(
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int HALT_REPEAT = DEF_HALT_REPEAT,
    parameter int MAX_CYCLES  = DEF_MAX_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 retire,
    output logic                 core_reset,
    output logic                 running,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instr_cnt,
    output logic [PC_WIDTH-1:0]  last_pc
);
    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam int HRW = $clog2(HALT_REPEAT + 1);

    if (RST_CYCLES < 1) begin : g_bad_rst
        $error("RST_CYCLES must be >= 1");
    end
    if (HALT_REPEAT < 1) begin : g_bad_halt
        $error("HALT_REPEAT must be >= 1");
    end
    if (MAX_CYCLES < 1 || (CNT_WIDTH < 31 && MAX_CYCLES >= (1 << CNT_WIDTH))) begin : g_bad_max
        $error("MAX_CYCLES must be >= 1 and < 2**CNT_WIDTH");
    end

    state_e              state_q, state_d;
    logic [RCW-1:0]      rst_cnt_q, rst_cnt_d;
    logic [HRW-1:0]      rep_q, rep_d;
    logic [PC_WIDTH-1:0] last_pc_q, last_pc_d;
    logic                seen_q, seen_d;
    logic                in_run, go, retire_run, halt, budget;

    always_comb begin
        in_run     = state_q == S_RUN;
        go         = start && !abort && state_q inside {S_IDLE, S_DONE, S_TIMEOUT};
        retire_run = in_run && retire;
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        rep_d      = rep_q;
        last_pc_d  = last_pc_q;
        seen_d     = seen_q;
        if (retire_run) begin
            rep_d     = (seen_q && pc == last_pc_q) ? rep_q + 1'b1 : '0;
            last_pc_d = pc;
            seen_d    = 1'b1;
        end
        halt   = retire_run && rep_d == HRW'(HALT_REPEAT);
        budget = in_run && cycle_cnt >= CNT_WIDTH'(MAX_CYCLES - 1);
        if (go) begin
            state_d   = S_RESET;
            rst_cnt_d = RCW'(RST_CYCLES - 1);
            rep_d     = '0;
            last_pc_d = '0;
            seen_d    = 1'b0;
        end else if (abort && (state_q == S_RESET || in_run)) begin
            state_d = S_IDLE;
        end else if (state_q == S_RESET) begin
            rst_cnt_d = rst_cnt_q - 1'b1;
            state_d   = rst_cnt_q == '0 ? S_RUN : S_RESET;
        end else if (halt) begin
            state_d = S_DONE;
        end else if (budget) begin
            state_d = S_TIMEOUT;
        end
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q   <= S_IDLE;
            rst_cnt_q <= '0;
            rep_q     <= '0;
            last_pc_q <= '0;
            seen_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            rep_q     <= rep_d;
            last_pc_q <= last_pc_d;
            seen_q    <= seen_d;
        end

    sat_counter #(.W(CNT_WIDTH)) u_cycle_cnt (
        .clk(clk), .rst_n(reset), .clr_i(go), .en_i(in_run), .cnt_o(cycle_cnt)
    );
    sat_counter #(.W(CNT_WIDTH)) u_instr_cnt (
        .clk(clk), .rst_n(reset), .clr_i(go), .en_i(retire_run), .cnt_o(instr_cnt)
    );

    assign core_reset = state_q != S_RUN;
    assign running    = in_run;
    assign done       = state_q == S_DONE;
    assign timeout    = state_q == S_TIMEOUT;
    assign last_pc    = last_pc_q;
endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl: directed checks of reset sequencing, halt detection, timeout,
// abort, restart and asynchronous reset; instance b uses HALT_REPEAT=2.
module tb_mips_run_ctrl;
    logic clk = 1'b0;
    logic reset, start, abort, retire;
    logic [31:0] pc;
    logic a_cr, a_run, a_done, a_to, b_cr, b_run, b_done, b_to;
    logic [31:0] a_cyc, a_ins, a_lpc, b_cyc, b_ins, b_lpc;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mips_run_ctrl #(.PC_WIDTH(32), .CNT_WIDTH(32), .RST_CYCLES(4), .HALT_REPEAT(3), .MAX_CYCLES(20)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .pc(pc), .retire(retire),
        .core_reset(a_cr), .running(a_run), .done(a_done), .timeout(a_to),
        .cycle_cnt(a_cyc), .instr_cnt(a_ins), .last_pc(a_lpc)
    );
    mips_run_ctrl #(.PC_WIDTH(32), .CNT_WIDTH(32), .RST_CYCLES(4), .HALT_REPEAT(2), .MAX_CYCLES(20)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .pc(pc), .retire(retire),
        .core_reset(b_cr), .running(b_run), .done(b_done), .timeout(b_to),
        .cycle_cnt(b_cyc), .instr_cnt(b_ins), .last_pc(b_lpc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flags(input string tag, input logic cr, input logic rn, input logic dn, input logic to);
        chk({tag, "_core_reset"}, 32'(a_cr), 32'(cr));
        chk({tag, "_running"}, 32'(a_run), 32'(rn));
        chk({tag, "_done"}, 32'(a_done), 32'(dn));
        chk({tag, "_timeout"}, 32'(a_to), 32'(to));
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; retire = 1'b0; pc = '0;
        #2;
        flags("por", 1, 0, 0, 0);
        chk("por_cyc", a_cyc, 0);
        chk("por_ins", a_ins, 0);
        chk("por_lpc", a_lpc, 0);
        @(negedge clk) reset = 1'b1;
        tick(); tick();
        flags("idle", 1, 0, 0, 0);
        start = 1'b1; tick(); start = 1'b0;
        flags("rst0", 1, 0, 0, 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            flags("rst_hold", 1, 0, 0, 0);
        end
        tick();
        flags("run_entry", 0, 1, 0, 0);
        chk("run_entry_cyc", a_cyc, 0);
        tick();
        chk("run_first_cyc", a_cyc, 1);
        retire = 1'b1; pc = 32'h3000; tick();
        pc = 32'h3004; tick();
        pc = 32'h3008; tick(); tick(); tick();
        flags("pre_halt", 0, 1, 0, 0);
        chk("b_halt_done", 32'(b_done), 1);
        chk("b_halt_ins", b_ins, 5);
        tick(); retire = 1'b0;
        flags("halt", 1, 0, 1, 0);
        chk("halt_ins", a_ins, 6);
        chk("halt_lpc", a_lpc, 32'h3008);
        chk("halt_cyc", a_cyc, 7);
        retire = 1'b1; pc = 32'h4000; tick(); retire = 1'b0;
        chk("done_ign_ins", a_ins, 6);
        chk("done_ign_lpc", a_lpc, 32'h3008);
        start = 1'b1; tick(); start = 1'b0;
        flags("restart", 1, 0, 0, 0);
        chk("restart_cyc", a_cyc, 0);
        chk("restart_ins", a_ins, 0);
        chk("restart_lpc", a_lpc, 0);
        repeat (4) tick();
        flags("to_run", 0, 1, 0, 0);
        repeat (19) tick();
        chk("to_pre_cyc", a_cyc, 19);
        flags("to_pre", 0, 1, 0, 0);
        tick();
        flags("to", 1, 0, 0, 1);
        chk("to_cyc", a_cyc, 20);
        tick();
        chk("to_hold_cyc", a_cyc, 20);
        start = 1'b1; tick(); start = 1'b0;
        flags("to_restart", 1, 0, 0, 0);
        chk("to_restart_cyc", a_cyc, 0);
        repeat (4) tick();
        tick(); tick();
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        flags("abort_run", 1, 0, 0, 0);
        chk("abort_run_cyc", a_cyc, 3);
        repeat (6) tick();
        flags("abort_idle", 1, 0, 0, 0);
        chk("abort_idle_cyc", a_cyc, 3);
        start = 1'b1; tick(); start = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
        repeat (6) tick();
        flags("abort_rst", 1, 0, 0, 0);
        chk("abort_rst_cyc", a_cyc, 0);
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < 3; k++) begin
            retire = 1'b1; pc = 32'h3010; tick(); retire = 1'b0;
            if (k == 1) chk("stall_b_run", 32'(b_run), 1);
            if (k < 2) repeat (5) tick();
        end
        chk("stall_b_done", 32'(b_done), 1);
        chk("stall_b_cr", 32'(b_cr), 1);
        chk("stall_b_ins", b_ins, 3);
        chk("stall_a_run", 32'(a_run), 1);
        chk("stall_a_ins", a_ins, 3);
        chk("stall_a_cyc", a_cyc, 13);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        flags("async", 1, 0, 0, 0);
        chk("async_cyc", a_cyc, 0);
        chk("async_ins", a_ins, 0);
        chk("async_lpc", a_lpc, 0);
        chk("async_b_done", 32'(b_done), 0);
        @(negedge clk) reset = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        flags("post_async_run", 0, 1, 0, 0);
        tick();
        chk("post_async_cyc", a_cyc, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
